master_cmd_frame_tx: RTL and testbench
======================================

// Module: master_cmd_frame_tx
// PURPOSE
//  Initiator-side sequencer for the 3-byte command frame consumed by the slave processing FSM.
//  Latches {cmd, op_a, op_b} on a start request. Feeds each byte in order to the I2C master byte engine.
//  Waits for that engine's per-byte done pulse before presenting the next byte.
//  Counts completed frames (2-bit, mirrors the slave-side cnt) and reports NACK/timeout errors.
// PARAMETERS
//  TIMEOUT_CYCLES  1000  max clk cycles to wait for byte_done per byte before abort (>=2)
//  CMD_W           2     width of command field; zero-extended into byte 0
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  start        in   1  1-cycle request; sampled only in IDLE
//  cmd          in   CMD_W  command code (0..3), becomes byte 0
//  op_a         in   8  byte 1 payload
//  op_b         in   8  byte 2 payload
//  tx_data      out  8  byte presented to I2C master engine
//  tx_valid     out  1  level; tx_data valid, held until byte_done
//  byte_done    in   1  1-cycle pulse from engine: current byte finished
//  byte_nack    in   1  qualified by byte_done; 1 = slave NACKed the byte
//  busy         out  1  high from cycle after accepted start until return to IDLE
//  frame_done   out  1  1-cycle pulse, frame sent without error
//  err          out  1  1-cycle pulse, frame aborted (NACK or timeout)
//  frame_cnt    out  2  completed-frame counter, wraps 3->0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; tx_data=0, tx_valid=0, busy=0, frame_done=0, err=0, frame_cnt=0.
//  States: IDLE -> SEND -> (WAIT_GAP) -> DONE | ABORT -> IDLE.
//  IDLE: start=1 at edge N captures {cmd,op_a,op_b} into a 3-entry shadow and sets idx=0.
//    tx_valid=1 and busy=1 from edge N+1; tx_data=shadow[0].
//  SEND: tx_valid and tx_data held stable. byte_done with byte_nack=0: idx++.
//    If idx was last -> DONE, else WAIT_GAP. byte_done with byte_nack=1 -> ABORT.
//  WAIT_GAP: one cycle, tx_valid=0, so the engine sees a fresh valid edge. Then SEND with the next byte.
//  DONE: frame_done=1 for 1 cycle; frame_cnt+=1 (mod 4) on the same edge; -> IDLE, busy=0.
//  ABORT: err=1 for 1 cycle; frame_cnt unchanged; tx_valid=0; -> IDLE.
//  Timeout: per-byte counter cleared on entry to SEND. When it reaches TIMEOUT_CYCLES with no byte_done -> ABORT.
//  byte_done outside SEND: ignored. byte_done coincident with timeout expiry: byte_done wins.
//  start while busy: ignored, no queueing. start coincident with the DONE/ABORT cycle: ignored.
//  Inputs cmd/op_a/op_b may change after start; only latched values are sent.
//  rst_n low mid-frame: immediate return to reset values; partial frame is not counted.
//  Min frame latency (byte_done 1 cycle after each valid): start -> frame_done = 8 cycles.
// CONFIGURATION
//  FRAME_CHKSUM_EN defined: the frame has 4 bytes. Byte 3 = byte0^byte1^byte2, sent after op_b with the same handshake and WAIT_GAP.
//    A NACK or timeout on byte 3 -> ABORT.
//  FRAME_CHKSUM_EN undefined: 3-byte frame. No checksum logic is synthesised.
// STRUCTURE
//  Package master_frame_pkg holds:
//    state enum (IDLE, SEND, WAIT_GAP, DONE, ABORT);
//    FRAME_LEN (3, or 4 under FRAME_CHKSUM_EN);
//    IDX_W = $clog2(FRAME_LEN);
//    FCNT_W = 2.
//  Sub-module frame_timeout_ctr: clear/enable in, expired out, width $clog2(TIMEOUT_CYCLES+1).
//  Everything else stays in this module.
// TESTING
//  1 cmd=0, op_a=4, op_b=6, start; engine acks each byte after 3 cycles
//    -> tx_data 0x00, 0x04, 0x06 in order; one frame_done; frame_cnt=1.
//  2 Four back-to-back frames, cmd=0,1,2,3 (op 4,6)
//    -> frame_cnt 1, 2, 3, 0; byte 0 matches cmd each frame; tx_valid low >=1 cycle between bytes.
//  3 start pulsed again during byte 1 of a frame -> ignored: exactly 3 bytes sent, one frame_done.
//  4 byte_nack=1 with byte_done on byte 1 -> err pulse; op_b never presented; frame_cnt unchanged; busy=0 next cycle.
//  5 byte_done withheld, TIMEOUT_CYCLES=16 -> err exactly 16 cycles after tx_valid rose; then rst_n pulse mid-frame clears all outputs.
//  6 FRAME_CHKSUM_EN, cmd=1, 4, 6 -> 4th byte 0x03; cmd=0, 4, 6 -> 4th byte 0x02; frame_done only after byte 3 ack.

Source files
------------

// File: rtl/master_frame_pkg.sv
// Shared types and sizing for the initiator-side command frame sequencer.
// FRAME_CHKSUM_EN adds a trailing XOR checksum byte to every frame.
package master_frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitGap,
    StDone,
    StAbort
  } state_e;

`ifdef FRAME_CHKSUM_EN
  localparam int unsigned FRAME_LEN = 4;
`else
  localparam int unsigned FRAME_LEN = 3;
`endif

  localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
  localparam int unsigned FCNT_W = 2;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Per-byte watchdog: counts cycles spent waiting for byte_done and flags expiry.
module frame_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES));

  // Clear loads 1 because the cycle entering the wait already counts as the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CNT_W'(1);
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/master_cmd_frame_tx.sv
// Feeds a latched {cmd, op_a, op_b} frame byte-by-byte into the I2C master byte engine.
// FRAME_CHKSUM_EN appends byte0^byte1^byte2 as a fourth byte.
module master_cmd_frame_tx
  import master_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CMD_W          = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [7:0]        op_a,
  input  logic [7:0]        op_b,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              byte_done,
  input  logic              byte_nack,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       shadow [FRAME_LEN];
  logic [7:0]       byte0;
  logic             last_byte;
  logic             tmo_clear;
  logic             tmo_en;
  logic             tmo_expired;

  assign byte0     = 8'(cmd);
  assign last_byte = (idx == IDX_W'(FRAME_LEN - 1));
  // The watchdog restarts on every entry into StSend.
  assign tmo_clear = ((state == StIdle) && start) || (state == StWaitGap);
  assign tmo_en    = (state == StSend);

  frame_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      idx        <= '0;
      shadow     <= '{default: '0};
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            shadow[0] <= byte0;
            shadow[1] <= op_a;
            shadow[2] <= op_b;
`ifdef FRAME_CHKSUM_EN
            shadow[3] <= byte0 ^ op_a ^ op_b;
`endif
            idx      <= '0;
            tx_data  <= byte0;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= StSend;
          end
        end
        StSend: begin
          // byte_done takes priority over a coincident timeout.
          if (byte_done) begin
            tx_valid <= 1'b0;
            if (byte_nack) begin
              err   <= 1'b1;
              state <= StAbort;
            end else begin
              idx <= idx + 1'b1;
              if (last_byte) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
                state      <= StDone;
              end else begin
                state <= StWaitGap;
              end
            end
          end else if (tmo_expired) begin
            tx_valid <= 1'b0;
            err      <= 1'b1;
            state    <= StAbort;
          end
        end
        StWaitGap: begin
          tx_data  <= shadow[idx];
          tx_valid <= 1'b1;
          state    <= StSend;
        end
        StDone, StAbort: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_master_cmd_frame_tx.sv
// Randomised directed bench for master_cmd_frame_tx with an engine model and frame-level reference.
// Honours FRAME_CHKSUM_EN for the expected frame length and checksum byte.
module tb_master_cmd_frame_tx;

  localparam int unsigned TMO   = 16;
  localparam int unsigned CW    = 2;
  localparam int          NONE  = 99;
`ifdef FRAME_CHKSUM_EN
  localparam int          NBYTES = 4;
`else
  localparam int          NBYTES = 3;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cmd;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          byte_done;
  logic          byte_nack;
  logic          busy;
  logic          frame_done;
  logic          err;
  logic [1:0]    frame_cnt;

  master_cmd_frame_tx #(
    .TIMEOUT_CYCLES(TMO),
    .CMD_W         (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd       (cmd),
    .op_a      (op_a),
    .op_b      (op_b),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .byte_done (byte_done),
    .byte_nack (byte_nack),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors;
  int         checks;
  int         model_cnt;
  int         frame_no;
  logic [7:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Sends one frame through an engine model that acks each byte after 'delay' cycles,
  // NACKs byte nack_at, never acks byte hold_at, and re-pulses start on byte restart_at.
  task automatic run_frame(input logic [CW-1:0] c, input logic [7:0] a, input logic [7:0] b,
                           input int delay, input int nack_at, input int hold_at,
                           input int restart_at);
    logic [7:0] exp_q[$];
    int   stop, exp_n, held, cyc, rise_cyc, tmo_lat, ends, busy_after, n_done, n_err, cnt_done;
    logic prev_valid, ok, done_seen;
    string pfx;

    // Reference: the frame is the byte list, truncated at the first failing byte.
    exp_q = '{8'(c), a, b};
    if (NBYTES == 4) exp_q.push_back(8'(c) ^ a ^ b);
    stop = NBYTES;
    if (nack_at < stop) stop = nack_at;
    if (hold_at < stop) stop = hold_at;
    ok    = (stop == NBYTES);
    exp_n = ok ? NBYTES : stop + 1;
    if (ok) model_cnt = (model_cnt + 1) % 4;
    frame_no++;
    pfx = $sformatf("frame%0d", frame_no);

    cmd = c; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd = CW'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);

    obs_q.delete();
    n_done = 0; n_err = 0; cyc = 0; held = 0; rise_cyc = -1; tmo_lat = -1; ends = 0;
    busy_after = -1; cnt_done = -1; prev_valid = 1'b0; done_seen = 1'b0;
    while (cyc < 200 && busy_after < 0) begin
      start = 1'b0; byte_done = 1'b0; byte_nack = 1'b0;
      if (done_seen) begin
        busy_after = int'(busy);
      end else begin
        if (tx_valid && !prev_valid) begin
          obs_q.push_back(tx_data);
          held = 0;
          rise_cyc = cyc;
          if (obs_q.size() - 1 == restart_at) begin
            start = 1'b1;
            cmd = CW'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
          end
        end else if (tx_valid) begin
          held++;
        end
        if (!tx_valid && prev_valid) ends++;
        if (tx_valid && held == delay - 1 && obs_q.size() - 1 != hold_at) begin
          byte_done = 1'b1;
          byte_nack = (obs_q.size() - 1 == nack_at);
        end
        if (frame_done) begin n_done++; cnt_done = int'(frame_cnt); done_seen = 1'b1; end
        if (err) begin n_err++; tmo_lat = cyc - rise_cyc; done_seen = 1'b1; end
      end
      prev_valid = tx_valid;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; byte_done = 1'b0; byte_nack = 1'b0;

    check({pfx, "_completed"}, busy_after >= 0, 1);
    check({pfx, "_nbytes"}, obs_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < obs_q.size(); i++)
      check($sformatf("%s_byte%0d", pfx, i), obs_q[i], exp_q[i]);
    check({pfx, "_valid_gaps"}, ends, obs_q.size());
    check({pfx, "_frame_done"}, n_done, ok ? 1 : 0);
    check({pfx, "_err"}, n_err, ok ? 0 : 1);
    check({pfx, "_busy_after"}, busy_after, 0);
    check({pfx, "_frame_cnt"}, frame_cnt, model_cnt);
    if (ok) check({pfx, "_cnt_at_done"}, cnt_done, model_cnt);
    if (hold_at < NBYTES && hold_at < nack_at) check({pfx, "_timeout_lat"}, tmo_lat, TMO);
  endtask

  initial begin
    int nack_at, hold_at;
    errors = 0; checks = 0; model_cnt = 0; frame_no = 0;
    rst_n = 1'b0; start = 1'b0; cmd = '0; op_a = '0; op_b = '0;
    byte_done = 1'b0; byte_nack = 1'b0;

    // Reset state
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_flags", {frame_done, err}, 0);

    // Basic frame, then cmd 0..3 back to back
    run_frame(2'd0, 8'd4, 8'd6, 3, NONE, NONE, NONE);
    for (int c = 0; c < 4; c++) run_frame(CW'(c), 8'd4, 8'd6, 3, NONE, NONE, NONE);
    // Minimum-latency acks
    run_frame(2'd1, 8'd4, 8'd6, 1, NONE, NONE, NONE);
    // Start re-pulsed during byte 1
    run_frame(CW'($urandom), 8'($urandom), 8'($urandom), 2, NONE, NONE, 1);
    // NACK on byte 1
    run_frame(2'd2, 8'($urandom), 8'($urandom), 3, 1, NONE, NONE);
    // Timeout on byte 0 and on the last byte
    run_frame(CW'($urandom), 8'($urandom), 8'($urandom), 2, NONE, 0, NONE);
    run_frame(CW'($urandom), 8'($urandom), 8'($urandom), 2, NONE, NBYTES - 1, NONE);

    // Random frames with occasional NACK or withheld ack
    for (int k = 0; k < 8; k++) begin
      nack_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NBYTES - 1) : NONE;
      hold_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, NBYTES - 1) : NONE;
      run_frame(CW'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 5),
                nack_at, hold_at, NONE);
    end

    // Stray byte_done in IDLE is ignored
    byte_done = 1'b1;
    @(negedge clk);
    byte_done = 1'b0;
    @(negedge clk);
    check("stray_done_valid", tx_valid, 0);
    check("stray_done_cnt", frame_cnt, model_cnt);

    if (model_cnt == 0) run_frame(2'd3, 8'd4, 8'd6, 2, NONE, NONE, NONE);

    // Reset mid-frame
    cmd = 2'd1; op_a = 8'($urandom); op_b = 8'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_flags", {busy, tx_valid, frame_done, err}, 0);

    run_frame(CW'($urandom), 8'($urandom), 8'($urandom), 3, NONE, NONE, NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
